// File: rtl/jk_ff_bank.sv
// Bank of WIDTH independent JK/SR/D/T flip-flops with change flags and SR illegal-input error tracking.
// Latency: one clock from inputs to q/changed/sr_err, qbar zero latency; no backpressure, accepts every enabled edge.
module jk_ff_bank #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  input  logic             clr_err,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic [WIDTH-1:0] changed,
  output logic             any_changed,
  output logic             sr_err,
  output logic             err_sticky
);

  typedef enum logic [1:0] {
    MODE_JK = 2'b00,
    MODE_SR = 2'b01,
    MODE_D  = 2'b10,
    MODE_T  = 2'b11
  } mode_t;

  logic [WIDTH-1:0] q_nxt;
  logic             illegal;

  always_comb begin
    q_nxt   = q;
    illegal = 1'b0;
    unique case (mode_t'(mode))
      MODE_JK: q_nxt = (j & ~q) | (~k & q);
      // 11 holds the channel and is flagged as an error
      MODE_SR: begin
        q_nxt   = (j & ~k) | (q & ~(~j & k));
        illegal = |(j & k);
      end
      MODE_D:  q_nxt = j;
      MODE_T:  q_nxt = q ^ j;
      default: q_nxt = q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q          <= RESET_VAL;
      changed    <= '0;
      sr_err     <= 1'b0;
      err_sticky <= 1'b0;
    end else if (en) begin
      q          <= q_nxt;
      changed    <= q_nxt ^ q;
      sr_err     <= illegal;
      err_sticky <= illegal | (err_sticky & ~clr_err);
    end else begin
      changed    <= '0;
      sr_err     <= 1'b0;
      err_sticky <= err_sticky & ~clr_err;
    end
  end

  assign qbar        = ~q;
  assign any_changed = |changed;

endmodule

// File: tb/tb_jk_ff_bank.sv
// Directed bench for jk_ff_bank: two instances share stimulus, differing only in RESET_VAL (00 and 3C).
module tb_jk_ff_bank;

  logic       clk = 1'b0;
  logic       rst, en, clr_err;
  logic [1:0] mode;
  logic [7:0] j, k;

  logic [7:0] q0, qbar0, changed0, q1, qbar1, changed1;
  logic       any0, err0, sticky0, any1, err1, sticky1;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  jk_ff_bank #(.WIDTH(8), .RESET_VAL(8'h00)) dut0 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .j(j), .k(k), .clr_err(clr_err),
    .q(q0), .qbar(qbar0), .changed(changed0), .any_changed(any0),
    .sr_err(err0), .err_sticky(sticky0)
  );

  jk_ff_bank #(.WIDTH(8), .RESET_VAL(8'h3C)) dut1 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .j(j), .k(k), .clr_err(clr_err),
    .q(q1), .qbar(qbar1), .changed(changed1), .any_changed(any1),
    .sr_err(err1), .err_sticky(sticky1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic e, input logic [1:0] m, input logic [7:0] jv, input logic [7:0] kv);
    en = e; mode = m; j = jv; k = kv;
  endtask

  task automatic test_reset();
    rst = 1'b1; clr_err = 1'b0; drive(1'b0, 2'b00, 8'h00, 8'h00);
    tick();
    rst = 1'b0;
    checks++; if (q0 !== 8'h00) $display("FAIL reset_q0 got %h want 00", q0); else passed++;
    checks++; if (qbar0 !== 8'hFF) $display("FAIL reset_qbar0 got %h want FF", qbar0); else passed++;
    checks++; if (q1 !== 8'h3C) $display("FAIL reset_q1 got %h want 3C", q1); else passed++;
    checks++; if (changed0 !== 8'h00 || any0 !== 1'b0) $display("FAIL reset_changed got %h/%b want 00/0", changed0, any0); else passed++;
    checks++; if (err0 !== 1'b0 || sticky0 !== 1'b0) $display("FAIL reset_err got %b/%b want 0/0", err0, sticky0); else passed++;
  endtask

  task automatic test_jk();
    logic [7:0] exp_q [3];
    exp_q[0] = 8'hFF; exp_q[1] = 8'h00; exp_q[2] = 8'hFF;
    drive(1'b1, 2'b00, 8'hFF, 8'hFF);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (q0 !== exp_q[i]) $display("FAIL jk_toggle_q[%0d] got %h want %h", i, q0, exp_q[i]); else passed++;
      checks++; if (changed0 !== 8'hFF || err0 !== 1'b0) $display("FAIL jk_toggle_flags[%0d] got %h/%b want FF/0", i, changed0, err0); else passed++;
    end
    // q=FF: set channels 0F, clear channels F0
    drive(1'b1, 2'b00, 8'h0F, 8'hF0);
    tick();
    checks++; if (q0 !== 8'h0F || changed0 !== 8'hF0) $display("FAIL jk_setclr got %h/%h want 0F/F0", q0, changed0); else passed++;
    drive(1'b1, 2'b00, 8'h00, 8'h00);
    tick();
    checks++; if (q0 !== 8'h0F || any0 !== 1'b0) $display("FAIL jk_hold got %h/%b want 0F/0", q0, any0); else passed++;
  endtask

  task automatic test_sr();
    drive(1'b1, 2'b10, 8'h0F, 8'h00);
    tick();
    drive(1'b1, 2'b01, 8'hF0, 8'h0F);
    tick();
    checks++; if (q0 !== 8'hF0 || changed0 !== 8'hFF || err0 !== 1'b0) $display("FAIL sr_setclr got %h/%h/%b want F0/FF/0", q0, changed0, err0); else passed++;
    drive(1'b1, 2'b01, 8'h01, 8'h01);
    tick();
    checks++; if (q0 !== 8'hF0 || changed0 !== 8'h00) $display("FAIL sr_illegal_hold got %h/%h want F0/00", q0, changed0); else passed++;
    checks++; if (err0 !== 1'b1 || sticky0 !== 1'b1) $display("FAIL sr_illegal_err got %b/%b want 1/1", err0, sticky0); else passed++;
    drive(1'b1, 2'b01, 8'h00, 8'h00);
    tick();
    checks++; if (err0 !== 1'b0 || sticky0 !== 1'b1) $display("FAIL sr_err_pulse got %b/%b want 0/1", err0, sticky0); else passed++;
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    checks++; if (sticky0 !== 1'b0 || q0 !== 8'hF0) $display("FAIL sr_clr got %b/%h want 0/F0", sticky0, q0); else passed++;
  endtask

  task automatic test_enable();
    drive(1'b1, 2'b10, 8'h55, 8'h00);
    tick();
    drive(1'b0, 2'b10, 8'hAA, 8'h00);
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (q0 !== 8'h55 || changed0 !== 8'h00 || any0 !== 1'b0) $display("FAIL en_gate[%0d] got %h/%h/%b want 55/00/0", i, q0, changed0, any0); else passed++;
    end
    drive(1'b0, 2'b01, 8'hFF, 8'hFF);
    tick();
    checks++; if (err0 !== 1'b0 || sticky0 !== 1'b0 || q0 !== 8'h55) $display("FAIL en_gate_sr got %b/%b/%h want 0/0/55", err0, sticky0, q0); else passed++;
    drive(1'b1, 2'b10, 8'hAA, 8'h00);
    tick();
    checks++; if (q0 !== 8'hAA || changed0 !== 8'hFF || qbar0 !== 8'h55) $display("FAIL en_resume got %h/%h/%h want AA/FF/55", q0, changed0, qbar0); else passed++;
  endtask

  task automatic test_t_mode();
    drive(1'b1, 2'b10, 8'h00, 8'h00);
    tick();
    drive(1'b1, 2'b11, 8'h81, 8'hFF);
    tick();
    checks++; if (q0 !== 8'h81 || changed0 !== 8'h81 || any0 !== 1'b1) $display("FAIL t_toggle got %h/%h/%b want 81/81/1", q0, changed0, any0); else passed++;
    drive(1'b1, 2'b11, 8'h00, 8'hFF);
    tick();
    checks++; if (q0 !== 8'h81 || changed0 !== 8'h00 || any0 !== 1'b0) $display("FAIL t_hold got %h/%h/%b want 81/00/0", q0, changed0, any0); else passed++;
  endtask

  task automatic test_reset_priority();
    drive(1'b1, 2'b10, 8'hFF, 8'h00);
    tick();
    drive(1'b1, 2'b01, 8'hFF, 8'hFF);
    tick();
    checks++; if (q1 !== 8'hFF || sticky1 !== 1'b1) $display("FAIL rstpri_setup got %h/%b want FF/1", q1, sticky1); else passed++;
    rst = 1'b1;
    drive(1'b1, 2'b00, 8'hFF, 8'hFF);
    tick();
    rst = 1'b0;
    checks++; if (q1 !== 8'h3C || q0 !== 8'h00) $display("FAIL rstpri_q got %h/%h want 3C/00", q1, q0); else passed++;
    checks++; if (changed1 !== 8'h00 || any1 !== 1'b0) $display("FAIL rstpri_changed got %h/%b want 00/0", changed1, any1); else passed++;
    checks++; if (err1 !== 1'b0 || sticky1 !== 1'b0) $display("FAIL rstpri_err got %b/%b want 0/0", err1, sticky1); else passed++;
  endtask

  task automatic test_set_wins();
    clr_err = 1'b1;
    drive(1'b1, 2'b01, 8'h02, 8'h02);
    tick();
    clr_err = 1'b0;
    checks++; if (err0 !== 1'b1 || sticky0 !== 1'b1) $display("FAIL setwins got %b/%b want 1/1", err0, sticky0); else passed++;
    checks++; if (q1 !== 8'h3C || changed1 !== 8'h00) $display("FAIL setwins_hold got %h/%h want 3C/00", q1, changed1); else passed++;
    // JK 11 toggles without raising an error
    drive(1'b1, 2'b00, 8'hFF, 8'hFF);
    tick();
    checks++; if (q1 !== 8'hC3 || err1 !== 1'b0 || sticky1 !== 1'b1) $display("FAIL jk11_noerr got %h/%b/%b want C3/0/1", q1, err1, sticky1); else passed++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_jk();
    test_sr();
    test_enable();
    test_t_mode();
    test_reset_priority();
    test_set_wins();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/jk_ff_bank.md
JK_FF_BANK -- requirements
Module: jk_ff_bank

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the number of independent flip-flop channels (legal range 1..64).
REQ-002 The block SHALL have parameter RESET_VAL, WIDTH bits, default all-zero, giving the value q takes on reset.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset.
REQ-004 Port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 Port rst  input  1  synchronous, active-high reset.
REQ-006 Port en  input  1  update enable; 1 = evaluate channels this edge.
REQ-007 Port mode  input  2  function select, common to all channels: 00 JK, 01 SR, 10 D, 11 T.
REQ-008 Port j  input  WIDTH  per-channel J / S / D / T input, depending on mode.
REQ-009 Port k  input  WIDTH  per-channel K / R input; ignored in D and T modes.
REQ-010 Port clr_err  input  1  clears the sticky error flag.
REQ-011 Port q  output  WIDTH  registered channel state.
REQ-012 Port qbar  output  WIDTH  bitwise inverse of q, combinational from q.
REQ-013 Port changed  output  WIDTH  registered per-channel flag: q[i] changed on the last edge.
REQ-014 Port any_changed  output  1  OR-reduction of changed.
REQ-015 Port sr_err  output  1  registered one-cycle pulse: illegal SR input seen on the last edge.
REQ-016 Port err_sticky  output  1  registered sticky copy of sr_err.

Function
REQ-017 Each edge with rst=0 and en=1, each channel i SHALL compute next q[i] from mode as follows:
- JK: 00 hold, 01 clear, 10 set, 11 toggle.
- SR: j=1,k=0 set; j=0,k=1 clear; 00 hold; 11 hold.
- D: q[i]=j[i].
- T: j[i]=1 toggle, else hold.
REQ-018 In SR mode, j[i]&k[i]=1 on any channel SHALL hold that channel and set sr_err=1 for exactly the following cycle.
REQ-019 The 11 combination SHALL raise sr_err only in SR mode; in JK mode it SHALL toggle without error.
REQ-020 With en=0, q SHALL hold, changed SHALL be all-zero and sr_err SHALL be 0 on that edge, regardless of j, k or mode.
REQ-021 changed[i] SHALL be 1 for the cycle after an edge on which q[i] took a different value, and 0 otherwise; it is valid in the same cycle as the new q.
REQ-022 Latency SHALL be one clock from j/k/mode/en sampling to q, changed and sr_err; qbar SHALL track q with zero latency.
REQ-023 err_sticky SHALL set on any edge where sr_err is set, and SHALL clear on an edge with clr_err=1.
REQ-024 If clr_err=1 on the same edge that sr_err sets, err_sticky SHALL end as 1 (set wins).
REQ-025 A mode change SHALL take effect on the same edge it is sampled; there SHALL be no pipeline across modes.
REQ-026 Channels SHALL be fully independent; no channel's next state may depend on another channel.

Reset
REQ-027 On an edge with rst=1, q SHALL load RESET_VAL, and changed, sr_err and err_sticky SHALL load 0.
REQ-028 rst SHALL take priority over en, mode, j, k and clr_err.
REQ-029 A change in q caused by reset SHALL NOT raise changed.
REQ-030 Asserting rst mid-operation SHALL discard that edge's evaluation entirely.

Verification
REQ-031 Reset, toggle: WIDTH=8, RESET_VAL=0; rst one edge, then mode=00, en=1, j=k=FF for 3 edges -> q=FF,00,FF; changed=FF each cycle; sr_err=0.
REQ-032 SR illegal and sticky error:
- mode=01, q=0F; j=F0, k=0F -> q=F0.
- Then j=k=01 -> q=F0, sr_err=1 for one cycle, err_sticky=1.
- Then clr_err=1 on an edge with no error -> err_sticky=0.
REQ-033 Enable gating: q=55, en=0, mode=10, j=AA for 4 edges -> q stays 55, changed=00, any_changed=0; then en=1 -> q=AA, changed=FF.
REQ-034 T mode with partial change: q=00, mode=11, j=81 -> q=81, changed=81, any_changed=1; then j=00 -> q=81, changed=00.
REQ-035 Reset priority: RESET_VAL=3C, q=FF, err_sticky=1; rst=1 with en=1, mode=00, j=k=FF -> q=3C, changed=00, sr_err=0, err_sticky=0.
REQ-036 Set-wins collision: mode=01, j=k=02, clr_err=1 on the same edge -> sr_err=1, err_sticky=1.
